// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with valid/ready backpressure.
// Define FP_MUL_SPECIAL_EN to decode Inf/NaN operands; otherwise only zero/subnormal flush applies.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] fp_X,
  input  logic [EXP_W+MAN_W:0] fp_Y,
  input  logic [2:0]           r_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] fp_Z,
  output logic                 ovrf,
  output logic                 udrf
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

  logic advance;
  logic vld3_q;
  assign advance   = !vld3_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld3_q;

  // Stage 1: unpack, classify, exponent sum and significand product
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] mx, my;
  logic             x_zero, y_zero;
  logic             s1_zero_d, s1_inf_d, s1_nan_d;
  logic [EW-1:0]    s1_exp_d;
  logic [PW-1:0]    s1_prod_d;

  assign ex        = fp_X[W-2:MAN_W];
  assign ey        = fp_Y[W-2:MAN_W];
  assign mx        = fp_X[MAN_W-1:0];
  assign my        = fp_Y[MAN_W-1:0];
  assign x_zero    = (ex == '0);
  assign y_zero    = (ey == '0);
  assign s1_exp_d  = EW'(ex) + EW'(ey) - BIAS_E;
  assign s1_prod_d = PW'({1'b1, mx}) * PW'({1'b1, my});

`ifdef FP_MUL_SPECIAL_EN
  logic x_inf, y_inf, x_nan, y_nan;
  assign x_inf     = (ex == '1) && (mx == '0);
  assign y_inf     = (ey == '1) && (my == '0);
  assign x_nan     = (ex == '1) && (mx != '0);
  assign y_nan     = (ey == '1) && (my != '0);
  assign s1_nan_d  = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
  assign s1_inf_d  = (x_inf | y_inf) & !s1_nan_d;
  assign s1_zero_d = (x_zero | y_zero) & !s1_nan_d & !s1_inf_d;
`else
  assign s1_nan_d  = 1'b0;
  assign s1_inf_d  = 1'b0;
  assign s1_zero_d = x_zero | y_zero;
`endif

  logic             s1_vld_q, s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q;
  logic [EW-1:0]    s1_exp_q;
  logic [PW-1:0]    s1_prod_q;
  logic [2:0]       s1_rm_q;

  // Stage 2: normalise and form guard/round/sticky
  logic [MAN_W-1:0] s2_frac_d;
  logic [EW-1:0]    s2_exp_d;
  logic             s2_g_d, s2_r_d, s2_s_d;

  always_comb begin
    s2_frac_d = s1_prod_q[PW-3 -: MAN_W];
    s2_exp_d  = s1_exp_q;
    s2_g_d    = s1_prod_q[MAN_W-1];
    s2_r_d    = s1_prod_q[MAN_W-2];
    s2_s_d    = |s1_prod_q[MAN_W-3:0];
    if (s1_prod_q[PW-1]) begin
      s2_frac_d = s1_prod_q[PW-2 -: MAN_W];
      s2_exp_d  = s1_exp_q + EW'(1);
      s2_g_d    = s1_prod_q[MAN_W];
      s2_r_d    = s1_prod_q[MAN_W-1];
      s2_s_d    = |s1_prod_q[MAN_W-2:0];
    end
  end

  logic             s2_vld_q, s2_sign_q, s2_zero_q, s2_inf_q, s2_nan_q;
  logic             s2_g_q, s2_r_q, s2_s_q;
  logic [EW-1:0]    s2_exp_q;
  logic [MAN_W-1:0] s2_frac_q;
  logic [2:0]       s2_rm_q;

  // Stage 3: round, range check, pack
  logic             inc, to_inf;
  logic [MAN_W:0]   rnd;
  logic [EW-1:0]    exp_r;
  logic [W-1:0]     z_d;
  logic             ovf_d, udf_d;

  always_comb begin
    case (s2_rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s2_sign_q & (s2_g_q | s2_r_q | s2_s_q);
      3'b011:  inc = !s2_sign_q & (s2_g_q | s2_r_q | s2_s_q);
      3'b100:  inc = s2_g_q;
      default: inc = s2_g_q & (s2_r_q | s2_s_q | s2_frac_q[0]);
    endcase
    case (s2_rm_q)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = s2_sign_q;
      3'b011:  to_inf = !s2_sign_q;
      default: to_inf = 1'b1;
    endcase
    // A carry out leaves the fraction bits at zero, so only the exponent needs bumping
    rnd   = {1'b0, s2_frac_q} + (MAN_W+1)'(inc);
    exp_r = s2_exp_q + EW'(rnd[MAN_W]);
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (s2_nan_q) begin
      z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_inf_q) begin
      z_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero_q) begin
      z_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (!exp_r[EW-1] && (exp_r >= EMAX_E)) begin
      ovf_d = 1'b1;
      z_d   = to_inf ? {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                     : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      udf_d = 1'b1;
      z_d   = {s2_sign_q, {(W-1){1'b0}}};
    end else begin
      z_d = {s2_sign_q, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
    end
  end

  logic [W-1:0] z_q;
  logic         ovf_q, udf_q;
  assign fp_Z = z_q;
  assign ovrf = ovf_q;
  assign udrf = udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0; s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_inf_q <= 1'b0; s1_nan_q <= 1'b0;
      s1_exp_q <= '0;   s1_prod_q <= '0;   s1_rm_q   <= '0;
      s2_vld_q <= 1'b0; s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_inf_q <= 1'b0; s2_nan_q <= 1'b0;
      s2_g_q   <= 1'b0; s2_r_q    <= 1'b0; s2_s_q    <= 1'b0;
      s2_exp_q <= '0;   s2_frac_q <= '0;   s2_rm_q   <= '0;
      vld3_q   <= 1'b0; z_q       <= '0;   ovf_q     <= 1'b0; udf_q <= 1'b0;
    end else if (advance) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= fp_X[W-1] ^ fp_Y[W-1];
        s1_zero_q <= s1_zero_d;
        s1_inf_q  <= s1_inf_d;
        s1_nan_q  <= s1_nan_d;
        s1_exp_q  <= s1_exp_d;
        s1_prod_q <= s1_prod_d;
        s1_rm_q   <= r_mode;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_inf_q  <= s1_inf_q;
        s2_nan_q  <= s1_nan_q;
        s2_exp_q  <= s2_exp_d;
        s2_frac_q <= s2_frac_d;
        s2_g_q    <= s2_g_d;
        s2_r_q    <= s2_r_d;
        s2_s_q    <= s2_s_d;
        s2_rm_q   <= s1_rm_q;
      end
      vld3_q <= s2_vld_q;
      if (s2_vld_q) begin
        z_q   <= z_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
      end
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor to the combinational FP32 multiplier and generalises the exponent and mantissa widths. It adds a valid/ready handshake with full-pipeline backpressure, correct directed rounding and optional special-value handling. It sits in the FPU ALU datapath beside the adder, between the operand-issue logic and the result writeback.

## Interface
- EXP_W, default 8: exponent width.
- MAN_W, default 23: stored fraction width, with no hidden bit.
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- fp_X  in  W  operand X.
- fp_Y  in  W  operand Y.
- r_mode  in  3  rounding mode; captured with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- fp_Z  out  W  product.
- ovrf  out  1  overflow flag, qualified by out_valid.
- udrf  out  1  underflow flag, qualified by out_valid.

## Operation
- Pipeline stages:
  - S1: unpack operands, compute sign, compute the (EXP_W+2)-bit signed exponent eX+eY-BIAS, and compute the 2(MAN_W+1)-bit significand product.
  - S2: normalise. If the product MSB is set, take the upper MAN_W+1 bits and add 1 to the exponent; otherwise shift left by 1. Form guard bit, round bit and sticky bit; sticky is the OR of all lower bits.
  - S3: round, detect overflow/underflow, pack the result.
- Sign of every result (including zero) = X[W-1] XOR Y[W-1].
- Subnormal handling (flush to zero):
  - An operand with exponent 0 is treated as zero.
  - A zero or subnormal operand times a finite operand gives a signed zero, with ovrf=0 and udrf=0.
- Rounding, where inc means "add 1 ulp to the truncated fraction":
  - 000 RNE: inc = G & (R | S | lsb).
  - 001 RTZ: inc = 0.
  - 010 RDN: inc = sign & (G | R | S).
  - 011 RUP: inc = !sign & (G | R | S).
  - 100 RMM: inc = G.
  - 101–111: behave as RNE.
- Carry out of rounding: when the increment carries out of the significand, the fraction becomes 0 and the exponent increments.
- Overflow: biased exponent after rounding ≥ 2^EXP_W-1 sets ovrf=1. fp_Z is then:
  - signed infinity for RNE and RMM;
  - max finite for RTZ;
  - for RDN: infinity if negative, else max finite;
  - for RUP: infinity if positive, else max finite.
- Underflow: biased exponent after rounding ≤ 0 sets udrf=1 and fp_Z = signed zero (flush to zero, no subnormal outputs).

## Timing
- Latency: 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall.
- Throughput: 1 result per cycle.
- Advance condition: advance = !out_valid | out_ready; in_ready = advance (combinational).
- Stall: when advance=0, all stage registers hold, and fp_Z, ovrf and udrf stay stable while out_valid=1.
- Bubbles: each stage carries a valid bit. Bubbles propagate and are not compressed.
- Simultaneous accept and output in the same cycle is legal and loses nothing.
- Reset values: out_valid=0, fp_Z=0, ovrf=0, udrf=0, and all stage valid bits 0.
- In-flight operations are discarded on reset. in_ready=1 the cycle after reset is released.
- in_valid without in_ready: operands are not captured. The source must hold them.

## Configuration
- FP_MUL_SPECIAL_EN defined:
  - Exponent all-ones operands are decoded as Inf or NaN.
  - A NaN operand gives the canonical quiet NaN {0, all-ones exponent, 1 followed by MAN_W-1 zeros}.
  - Inf × zero/subnormal gives the canonical NaN.
  - Inf × finite-nonzero or Inf × Inf gives a signed Inf.
  - ovrf=0 and udrf=0 for all of these cases.
- FP_MUL_SPECIAL_EN undefined:
  - No Inf/NaN decode; exponent all-ones operands go through the normal datapath.
  - The zero/subnormal flush still applies regardless of the other operand.

## Test plan
- Basic: 0x3FC00000 × 0x40000000, RNE → 0x40400000 exactly 3 cycles after acceptance; ovrf=0, udrf=0.
- Rounding: 0x3F800001 × 0x3F800001 → RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003; with X sign bit set, RDN → 0xBF800003.
- Overflow: 0x7F000000 × 0x7F000000 → RNE 0x7F800000, ovrf=1; RTZ 0x7F7FFFFF, ovrf=1. Underflow: 0x00800000 × 0x00800000 → 0x00000000, udrf=1.
- Subnormal and zero: 0x00000001 × 0xC0000000 → 0x80000000, no flags.
- Special values (macro on): 0x7F800000 × 0x00000000 → 0x7FC00000; 0x7F800000 × 0xBF800000 → 0xFF800000.
- Backpressure and reset: stream 5 back-to-back operations with out_ready=0 → in_ready drops after 3 are accepted and fp_Z stays constant. Release out_ready → all 5 results delivered in order, none lost. Assert rst_n mid-stream → out_valid=0 immediately, no stale result afterwards.
